// File: rtl/add_serial_8bit_pkg.sv
// Shared types and helpers for the bit-serial adder.
package add_serial_pkg;

  localparam int unsigned ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Bit counter width; a 1-bit floor keeps the counter legal for the narrowest widths.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_serial_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface add_serial_8bit_if
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  S, C_out, busy, done
  );

  modport slave (
    input  start, A, B,
    output S, C_out, busy, done
  );

endinterface

// File: rtl/add_serial_8bit_fa_1bit.sv
// Single combinational full-adder cell shared by every bit position.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the parity of the inputs; carry is their majority.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/add_serial_8bit.sv
// Bit-serial unsigned adder: one full-adder cell walks the operands LSB first over WIDTH cycles.
module add_serial_8bit
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  add_serial_8bit_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  add_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] r_q;     // low sum bits gathered so far; the top bit joins on the last edge
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             c_q;
  logic [CntW-1:0]  cnt_q;
  logic             sum_bit;
  logic             carry_bit;

  fa_1bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (sum_bit),
    .cout (carry_bit)
  );

  // FSM and datapath; S/C_out load only on the final RUN edge so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= (r_q >> 1) | ((WIDTH - 1)'(sum_bit) << (WIDTH - 2));
          c_q   <= carry_bit;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            s_q     <= {sum_bit, r_q};
            cout_q  <= carry_bit;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status decoded purely from registered state.
  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    bus.S     = s_q;
    bus.C_out = cout_q;
  end

endmodule

// File: tb/tb_add_serial_8bit.sv
// Scoreboard bench for the bit-serial adder: driver pushes A+B, monitor pops on every done.
module tb_add_serial_8bit;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_serial_8bit_if #(.WIDTH(W)) bus ();

  add_serial_8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W:0]  sum;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned done_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [W:0]  last_res = '0;
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pops one expectation; between dones the result must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %0h, expected no done (cycle %0d)",
                 {bus.C_out, bus.S}, cyc);
      end else begin
        e = sb.pop_front();
        chk("sum", {23'd0, bus.C_out, bus.S}, {23'd0, e.sum});
        chk("latency", cyc - e.acc, W);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
      end
      last_res = {bus.C_out, bus.S};
      done_cyc.push_back(cyc);
    end else begin
      chk("result_hold", {23'd0, bus.C_out, bus.S}, {23'd0, last_res});
    end
  end

  // Waits for IDLE/DONE, presents operands, records the expected sum at the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int k = 0;
    while (bus.busy && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got busy=1 after %0d cycles, expected idle", k);
      return;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    sb.push_back('{sum: {1'b0, a} + {1'b0, b}, acc: cyc});
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_S"}, {24'd0, bus.S}, 32'd0);
    chk({tag, "_C_out"}, {31'd0, bus.C_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state
    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
    end

    // Carry-out and no-carry cases
    issue(8'hFF, 8'h01, 1'b0);
    wait_drain();
    issue(8'h5A, 8'h25, 1'b0);
    wait_drain();

    // Back-to-back issue with start held high
    done_cyc.delete();
    issue(8'h80, 8'h80, 1'b1);
    issue(8'h01, 8'h02, 1'b0);
    wait_drain();
    chk("b2b_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2) chk("b2b_gap", done_cyc[1] - done_cyc[0], W + 1);

    // Request during RUN must be ignored
    issue(8'h33, 8'h44, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 8'h10;
    bus.B     = 8'h10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain();
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of RUN
    issue(8'hC3, 8'h5E, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    // Random operands with random back-to-back issue
    for (int i = 0; i < 100; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000 ns, expected completion");
    $fatal(1);
  end

endmodule
